// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared RV32I pipeline types: word/register typedefs, the opcode enum,
// the decoded control word carried down the pipe, and the operand-usage
// helpers (uses_rs1 / uses_rs2) so that decode and hazard logic agree on
// which instructions actually read a source register.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    // Major opcodes use the architectural 7-bit encodings.
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  alu_op;
        logic [2:0]  funct3;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } rv32i_control_word;

    // All-zero control word: a bubble that writes nothing and touches no memory.
    localparam rv32i_control_word CTRL_NOP = '0;

    // Instructions that read rs1 (everything except the U-type and JAL forms).
    function automatic logic uses_rs1(input rv32i_opcode opcode);
        logic used;
        case (opcode)
            op_lui, op_auipc, op_jal: used = 1'b0;
            default:                  used = 1'b1;
        endcase
        return used;
    endfunction

    // Instructions that read rs2 (R-type, stores, branches).
    function automatic logic uses_rs2(input rv32i_opcode opcode);
        logic used;
        case (opcode)
            op_reg, op_store, op_br: used = 1'b1;
            default:                 used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// id_ex_stage_load_use_detect
// Combinational load-use hazard detector. Flags the case where EX holds a
// load whose destination is read by the instruction currently in ID, so the
// pipeline must insert one bubble and hold PC and IF/ID.
//
// Ports:
//   ex_valid, ex_mem_read, ex_rd_num   - EX stage instruction state
//   id_valid, id_opcode                - ID stage instruction
//   id_rs1_num, id_rs2_num             - ID source register numbers
//   flush                              - ID instruction is being squashed
//   load_use_stall                     - hazard flag (combinational)
// ---------------------------------------------------------------------------
module id_ex_stage_load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  rv32i_reg    ex_rd_num,
    input  logic        id_valid,
    input  rv32i_opcode id_opcode,
    input  rv32i_reg    id_rs1_num,
    input  rv32i_reg    id_rs2_num,
    input  logic        flush,
    output logic        load_use_stall
);

    logic ex_is_load_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // Hazard detection: x0 destinations never create a dependency, and a
    // flushed ID instruction cannot consume anything.
    always_comb begin
        ex_is_load_s   = ex_valid && ex_mem_read && (ex_rd_num != 5'd0);
        rs1_hit_s      = uses_rs1(id_opcode) && (id_rs1_num == ex_rd_num);
        rs2_hit_s      = uses_rs2(id_opcode) && (id_rs2_num == ex_rd_num);
        if (flush) begin
            load_use_stall = 1'b0;
        end else begin
            load_use_stall = ex_is_load_s && id_valid && (rs1_hit_s || rs2_hit_s);
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage RV32I pipeline.
// Captures the ID instruction (operands after WB->ID forwarding, control
// word, PC, immediate, register numbers) and presents it to EX one cycle
// later. Supports hold (stall_in), squash (flush) and load-use bubble
// insertion. While holding, WB writes to the held source registers are
// snooped into the held operand data so it never goes stale.
//
// Edge priority: rst > flush > stall_in > load_use > capture.
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   stall_in, flush                  - downstream hold, redirect squash
//   ID_valid, ID_pc, ctrl_word       - ID instruction
//   ID_rs1_num/rs2_num/rd_num        - ID register numbers
//   forward_ID_rs1/rs2, ID_imm       - ID operands and immediate
//   WB_ctrlword, WB_rd_num, WB_rd_data - writeback port used for snooping
//   EX_*                             - registered EX stage contents
//   load_use_stall                   - combinational upstream hold request
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              ID_valid,
    input  rv32i_word         ID_pc,
    input  rv32i_control_word ctrl_word,
    input  rv32i_reg          ID_rs1_num,
    input  rv32i_reg          ID_rs2_num,
    input  rv32i_reg          ID_rd_num,
    input  rv32i_word         forward_ID_rs1,
    input  rv32i_word         forward_ID_rs2,
    input  rv32i_word         ID_imm,
    input  rv32i_control_word WB_ctrlword,
    input  rv32i_reg          WB_rd_num,
    input  rv32i_word         WB_rd_data,
    output logic              EX_valid,
    output rv32i_word         EX_pc,
    output rv32i_control_word EX_ctrlword,
    output rv32i_reg          EX_rs1_num,
    output rv32i_reg          EX_rs2_num,
    output rv32i_reg          EX_rd_num,
    output rv32i_word         EX_rs1_data,
    output rv32i_word         EX_rs2_data,
    output rv32i_word         EX_imm,
    output logic              load_use_stall
);

    logic              ex_valid_r;
    rv32i_word         ex_pc_r;
    rv32i_control_word ex_ctrl_r;
    rv32i_reg          ex_rs1_num_r;
    rv32i_reg          ex_rs2_num_r;
    rv32i_reg          ex_rd_num_r;
    rv32i_word         ex_rs1_data_r;
    rv32i_word         ex_rs2_data_r;
    rv32i_word         ex_imm_r;

    logic              load_use_s;
    logic              wb_writes_s;
    logic              snoop_rs1_s;
    logic              snoop_rs2_s;

    // Only load_regfile of the WB control word matters here.
    logic              wb_ctrl_unused_s;
    assign wb_ctrl_unused_s = ^{WB_ctrlword};

    id_ex_stage_load_use_detect u_load_use_detect (
        .ex_valid       (ex_valid_r),
        .ex_mem_read    (ex_ctrl_r.mem_read),
        .ex_rd_num      (ex_rd_num_r),
        .id_valid       (ID_valid),
        .id_opcode      (ctrl_word.opcode),
        .id_rs1_num     (ID_rs1_num),
        .id_rs2_num     (ID_rs2_num),
        .flush          (flush),
        .load_use_stall (load_use_s)
    );

    // Snoop match: a real WB write to a nonzero register that a held, valid
    // EX instruction reads.
    always_comb begin
        wb_writes_s = WB_ctrlword.load_regfile && (WB_rd_num != 5'd0) && ex_valid_r;
        snoop_rs1_s = wb_writes_s && (WB_rd_num == ex_rs1_num_r);
        snoop_rs2_s = wb_writes_s && (WB_rd_num == ex_rs2_num_r);
    end

    // EX pipeline register update in edge-priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r    <= 1'b0;
            ex_pc_r       <= RESET_PC;
            ex_ctrl_r     <= CTRL_NOP;
            ex_rs1_num_r  <= 5'd0;
            ex_rs2_num_r  <= 5'd0;
            ex_rd_num_r   <= 5'd0;
            ex_rs1_data_r <= 32'd0;
            ex_rs2_data_r <= 32'd0;
            ex_imm_r      <= 32'd0;
        end else if (flush) begin
            // Squash: the remaining fields are cleared so the bubble is deterministic.
            ex_valid_r    <= 1'b0;
            ex_pc_r       <= 32'd0;
            ex_ctrl_r     <= CTRL_NOP;
            ex_rs1_num_r  <= 5'd0;
            ex_rs2_num_r  <= 5'd0;
            ex_rd_num_r   <= 5'd0;
            ex_rs1_data_r <= 32'd0;
            ex_rs2_data_r <= 32'd0;
            ex_imm_r      <= 32'd0;
        end else if (stall_in) begin
            // Hold everything, but refresh operands the WB stage is writing now;
            // otherwise the held instruction would execute with stale data.
            if (snoop_rs1_s) begin
                ex_rs1_data_r <= WB_rd_data;
            end
            if (snoop_rs2_s) begin
                ex_rs2_data_r <= WB_rd_data;
            end
        end else if (load_use_s) begin
            // Bubble; IF/ID is held upstream so the same ID instruction returns.
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= CTRL_NOP;
        end else begin
            ex_valid_r    <= ID_valid;
            ex_pc_r       <= ID_pc;
            ex_ctrl_r     <= ID_valid ? ctrl_word : CTRL_NOP;
            ex_rs1_num_r  <= ID_rs1_num;
            ex_rs2_num_r  <= ID_rs2_num;
            ex_rd_num_r   <= ID_rd_num;
            ex_rs1_data_r <= forward_ID_rs1;
            ex_rs2_data_r <= forward_ID_rs2;
            ex_imm_r      <= ID_imm;
        end
    end

    assign EX_valid       = ex_valid_r;
    assign EX_pc          = ex_pc_r;
    assign EX_ctrlword    = ex_ctrl_r;
    assign EX_rs1_num     = ex_rs1_num_r;
    assign EX_rs2_num     = ex_rs2_num_r;
    assign EX_rd_num      = ex_rd_num_r;
    assign EX_rs1_data    = ex_rs1_data_r;
    assign EX_rs2_data    = ex_rs2_data_r;
    assign EX_imm         = ex_imm_r;
    assign load_use_stall = load_use_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural EX-stage model.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h00000060;

    logic              clk = 1'b0;
    logic              rst, stall_in, flush, ID_valid;
    rv32i_word         ID_pc, forward_ID_rs1, forward_ID_rs2, ID_imm, WB_rd_data;
    rv32i_control_word ctrl_word, WB_ctrlword;
    rv32i_reg          ID_rs1_num, ID_rs2_num, ID_rd_num, WB_rd_num;
    logic              EX_valid, load_use_stall;
    rv32i_word         EX_pc, EX_rs1_data, EX_rs2_data, EX_imm;
    rv32i_control_word EX_ctrlword;
    rv32i_reg          EX_rs1_num, EX_rs2_num, EX_rd_num;

    always #5 clk = ~clk;

    id_ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .ID_valid(ID_valid), .ID_pc(ID_pc), .ctrl_word(ctrl_word),
        .ID_rs1_num(ID_rs1_num), .ID_rs2_num(ID_rs2_num), .ID_rd_num(ID_rd_num),
        .forward_ID_rs1(forward_ID_rs1), .forward_ID_rs2(forward_ID_rs2),
        .ID_imm(ID_imm), .WB_ctrlword(WB_ctrlword), .WB_rd_num(WB_rd_num),
        .WB_rd_data(WB_rd_data), .EX_valid(EX_valid), .EX_pc(EX_pc),
        .EX_ctrlword(EX_ctrlword), .EX_rs1_num(EX_rs1_num), .EX_rs2_num(EX_rs2_num),
        .EX_rd_num(EX_rd_num), .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
        .EX_imm(EX_imm), .load_use_stall(load_use_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model of the EX stage ----------------
    logic              m_valid;
    rv32i_word         m_pc, m_rs1d, m_rs2d, m_imm;
    rv32i_control_word m_ctrl;
    rv32i_reg          m_rs1n, m_rs2n, m_rdn;
    logic              lus_seen;

    function automatic logic reads_rs1(input rv32i_opcode op);
        return !(op inside {op_lui, op_auipc, op_jal});
    endfunction

    function automatic logic reads_rs2(input rv32i_opcode op);
        return op inside {op_reg, op_store, op_br};
    endfunction

    // A pending load in EX whose result the ID instruction needs.
    function automatic logic model_hazard();
        logic dep;
        dep = (reads_rs1(ctrl_word.opcode) && ID_rs1_num == m_rdn) ||
              (reads_rs2(ctrl_word.opcode) && ID_rs2_num == m_rdn);
        return !flush && m_valid && m_ctrl.mem_read && m_rdn != 5'd0 && ID_valid && dep;
    endfunction

    task automatic model_clear(input rv32i_word pc);
        m_valid = 1'b0; m_pc = pc; m_ctrl = '0;
        m_rs1n = 5'd0; m_rs2n = 5'd0; m_rdn = 5'd0;
        m_rs1d = 32'd0; m_rs2d = 32'd0; m_imm = 32'd0;
    endtask

    task automatic model_update(input logic hazard);
        if (rst) begin
            model_clear(RST_PC);
        end else if (flush) begin
            model_clear(32'd0);
        end else if (stall_in) begin
            if (m_valid && WB_ctrlword.load_regfile && WB_rd_num != 5'd0) begin
                if (WB_rd_num == m_rs1n) m_rs1d = WB_rd_data;
                if (WB_rd_num == m_rs2n) m_rs2d = WB_rd_data;
            end
        end else if (hazard) begin
            m_valid = 1'b0; m_ctrl = '0;
        end else begin
            m_valid = ID_valid; m_pc = ID_pc;
            m_ctrl = ID_valid ? ctrl_word : '0;
            m_rs1n = ID_rs1_num; m_rs2n = ID_rs2_num; m_rdn = ID_rd_num;
            m_rs1d = forward_ID_rs1; m_rs2d = forward_ID_rs2; m_imm = ID_imm;
        end
    endtask

    task automatic compare_all();
        check_val("EX_valid",    64'(EX_valid),    64'(m_valid));
        check_val("EX_pc",       64'(EX_pc),       64'(m_pc));
        check_val("EX_ctrlword", 64'(EX_ctrlword), 64'(m_ctrl));
        check_val("EX_rs1_num",  64'(EX_rs1_num),  64'(m_rs1n));
        check_val("EX_rs2_num",  64'(EX_rs2_num),  64'(m_rs2n));
        check_val("EX_rd_num",   64'(EX_rd_num),   64'(m_rdn));
        check_val("EX_rs1_data", 64'(EX_rs1_data), 64'(m_rs1d));
        check_val("EX_rs2_data", 64'(EX_rs2_data), 64'(m_rs2d));
        check_val("EX_imm",      64'(EX_imm),      64'(m_imm));
    endtask

    // One cycle: inputs are already set just after a negedge.
    task automatic step();
        logic exp_lus;
        #1;
        exp_lus  = model_hazard();
        lus_seen = load_use_stall;
        check_val("load_use_stall", 64'(load_use_stall), 64'(exp_lus));
        @(posedge clk);
        model_update(exp_lus);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic rv32i_control_word mk(input rv32i_opcode op);
        rv32i_control_word c;
        c = '0;
        c.opcode       = op;
        c.alu_op       = 3'($urandom_range(0, 7));
        c.funct3       = 3'($urandom_range(0, 7));
        c.load_regfile = !(op inside {op_store, op_br});
        c.mem_read     = (op == op_load);
        c.mem_write    = (op == op_store);
        c.branch       = (op == op_br);
        c.jump         = op inside {op_jal, op_jalr};
        return c;
    endfunction

    task automatic set_id(input logic v, input rv32i_opcode op, input rv32i_word pc,
                          input rv32i_reg rs1, input rv32i_reg rs2, input rv32i_reg rd,
                          input rv32i_word imm);
        ID_valid = v; ctrl_word = mk(op); ID_pc = pc;
        ID_rs1_num = rs1; ID_rs2_num = rs2; ID_rd_num = rd; ID_imm = imm;
        forward_ID_rs1 = $urandom; forward_ID_rs2 = $urandom;
    endtask

    task automatic wb_idle();
        WB_ctrlword = '0; WB_rd_num = 5'd0; WB_rd_data = 32'd0;
    endtask

    rv32i_opcode ops [9] = '{op_reg, op_imm, op_load, op_store, op_br,
                             op_lui, op_auipc, op_jal, op_jalr};
    rv32i_word   keep1, keep2;

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        set_id(1'b0, op_imm, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        wb_idle();
        model_clear(RST_PC);
        @(negedge clk);

        // Reset state
        step(); step();
        check_val("reset_pc", 64'(EX_pc), 64'(32'h60));
        check_val("reset_valid", 64'(EX_valid), 64'd0);
        rst = 1'b0;

        // addi x1,x0,5
        set_id(1'b1, op_imm, 32'h64, 5'd0, 5'd0, 5'd1, 32'd5); step();
        check_val("addi_valid", 64'(EX_valid), 64'd1);
        check_val("addi_pc", 64'(EX_pc), 64'h64);
        check_val("addi_imm", 64'(EX_imm), 64'd5);
        check_val("addi_rd", 64'(EX_rd_num), 64'd1);

        // lw x5 then add x6,x5,x7: one bubble, then the add enters EX
        set_id(1'b1, op_load, 32'h68, 5'd2, 5'd0, 5'd5, 32'd0); step();
        set_id(1'b1, op_reg, 32'h6c, 5'd5, 5'd7, 5'd6, 32'd0); step();
        check_val("lu_add_stall", 64'(lus_seen), 64'd1);
        check_val("lu_bubble_valid", 64'(EX_valid), 64'd0);
        check_val("lu_bubble_ctrl", 64'(EX_ctrlword), 64'd0);
        step();
        check_val("lu_add_enters", 64'(EX_rd_num), 64'd6);
        check_val("lu_add_pc", 64'(EX_pc), 64'h6c);

        // lw x5 then addi x6,x0,1 with rs2 field 5: no hazard
        set_id(1'b1, op_load, 32'h70, 5'd2, 5'd0, 5'd5, 32'd0); step();
        set_id(1'b1, op_imm, 32'h74, 5'd0, 5'd5, 5'd6, 32'd1); step();
        check_val("imm_rs2_nohaz", 64'(lus_seen), 64'd0);

        // lw x0 then instruction reading x0: no hazard
        set_id(1'b1, op_load, 32'h78, 5'd2, 5'd0, 5'd0, 32'd0); step();
        set_id(1'b1, op_reg, 32'h7c, 5'd0, 5'd0, 5'd8, 32'd0); step();
        check_val("x0_nohaz", 64'(lus_seen), 64'd0);

        // Stall with WB snoop of rs1=x3
        set_id(1'b1, op_reg, 32'h80, 5'd3, 5'd2, 5'd4, 32'd0);
        keep2 = forward_ID_rs2; step();
        stall_in = 1'b1;
        set_id(1'b1, op_imm, 32'h84, 5'd1, 5'd1, 5'd1, 32'd9); step();
        WB_ctrlword = mk(op_reg); WB_rd_num = 5'd3; WB_rd_data = 32'hDEADBEEF; step();
        check_val("snoop_rs1", 64'(EX_rs1_data), 64'hDEADBEEF);
        check_val("snoop_rs2_kept", 64'(EX_rs2_data), 64'(keep2));
        check_val("snoop_pc_kept", 64'(EX_pc), 64'h80);
        wb_idle(); step();
        stall_in = 1'b0;

        // WB write to x0 while holding an instruction that reads x0
        set_id(1'b1, op_reg, 32'h90, 5'd0, 5'd0, 5'd9, 32'd0);
        keep1 = forward_ID_rs1; step();
        stall_in = 1'b1;
        WB_ctrlword = mk(op_reg); WB_rd_num = 5'd0; WB_rd_data = 32'h12345678; step();
        check_val("snoop_x0", 64'(EX_rs1_data), 64'(keep1));
        wb_idle(); stall_in = 1'b0;

        // flush + stall + load-use condition
        set_id(1'b1, op_load, 32'hA0, 5'd2, 5'd0, 5'd5, 32'd0); step();
        set_id(1'b1, op_reg, 32'hA4, 5'd5, 5'd7, 5'd6, 32'd0);
        stall_in = 1'b1; flush = 1'b1; step();
        check_val("flush_gates_lus", 64'(lus_seen), 64'd0);
        check_val("flush_valid", 64'(EX_valid), 64'd0);
        stall_in = 1'b0; flush = 1'b0;

        // Reset during a stall with a live hazard
        set_id(1'b1, op_load, 32'hB0, 5'd2, 5'd0, 5'd5, 32'd0); step();
        set_id(1'b1, op_reg, 32'hB4, 5'd5, 5'd7, 5'd6, 32'd0);
        stall_in = 1'b1; step();
        check_val("stall_keeps_lus", 64'(lus_seen), 64'd1);
        rst = 1'b1; step();
        check_val("rst_stall_pc", 64'(EX_pc), 64'h60);
        check_val("rst_stall_valid", 64'(EX_valid), 64'd0);
        rst = 1'b0; stall_in = 1'b0; step();
        check_val("rst_after_lus", 64'(lus_seen), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            stall_in = ($urandom_range(0, 4) == 0);
            set_id($urandom_range(0, 9) < 8, ops[$urandom_range(0, 8)], $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom);
            WB_ctrlword = mk(ops[$urandom_range(0, 8)]);
            WB_rd_num   = 5'($urandom_range(0, 3));
            WB_rd_data  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, with load-use hazard detection.
- Captures post-forwarding ID operands, control word, PC, immediate and register numbers; presents them to EX.
- Handles stall (hold), flush (bubble) and load-use (bubble plus upstream hold).
- While holding, snoops WB writes so held operand data never goes stale.

Parameters:
- RESET_PC, 32'h00000060, PC value loaded into EX_pc on reset.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- stall_in  in  1  downstream (memory) busy; hold EX contents.
- flush  in  1  branch/jump redirect from EX; squash the instruction entering EX.
- ID_valid  in  1  ID holds a real instruction.
- ID_pc  in  32  PC of ID instruction.
- ctrl_word  in  rv32i_control_word  ID control word.
- ID_rs1_num, ID_rs2_num, ID_rd_num  in  5 each  ID register numbers.
- forward_ID_rs1, forward_ID_rs2  in  32 each  ID operands after WB->ID forwarding.
- ID_imm  in  32  decoded immediate.
- WB_ctrlword  in  rv32i_control_word  WB control word (load_regfile used).
- WB_rd_num  in  5  WB destination register.
- WB_rd_data  in  32  WB write data.
- EX_valid  out  1  EX holds a real instruction.
- EX_pc  out  32  EX PC.
- EX_ctrlword  out  rv32i_control_word  EX control word.
- EX_rs1_num, EX_rs2_num, EX_rd_num  out  5 each  EX register numbers.
- EX_rs1_data, EX_rs2_data  out  32 each  EX operands.
- EX_imm  out  32  EX immediate.
- load_use_stall  out  1  combinational; holds PC and IF/ID this cycle.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: EX_valid=0, EX_pc=RESET_PC, EX_ctrlword all fields 0 (load_regfile=0, mem_read=0, mem_write=0), all numbers/data/imm=0.
- Latency: one cycle from ID inputs to EX outputs.
- Per-edge priority: rst > flush > stall_in > load_use > capture.
- flush (with or without stall_in): EX_valid<=0, EX_ctrlword<=0. Other fields are don't-care but must be deterministic (load 0).
- stall_in (no flush): all EX registers hold. Exception is operand snoop.
- load_use (no flush, no stall_in): insert a bubble (EX_valid<=0, EX_ctrlword<=0). IF/ID holds upstream via load_use_stall, so the same ID instruction is captured next cycle.
- capture: every EX register takes its ID input; EX_valid<=ID_valid. If ID_valid=0, EX_ctrlword<=0.
- Operand snoop while holding: if WB_ctrlword.load_regfile && WB_rd_num!=0 && WB_rd_num==EX_rs1_num, then EX_rs1_data<=WB_rd_data. Same rule for rs2. Applies only when EX_valid=1.
- uses_rs2(opcode) is 1 for op_reg, op_store, op_br; else 0.
- uses_rs1(opcode) is 0 for op_lui, op_auipc, op_jal; else 1.
- load_use_stall = EX_valid && EX_ctrlword.mem_read && EX_rd_num!=0 && ID_valid && ((uses_rs1 && ID_rs1_num==EX_rd_num) || (uses_rs2 && ID_rs2_num==EX_rd_num)).
- load_use_stall is gated to 0 when flush=1 (the ID instruction is being squashed anyway).
- load_use_stall remains asserted combinationally while stall_in=1. Upstream must hold regardless.
- x0 is never a hazard and is never snooped.
- Reset asserted mid-stall clears everything on that edge. load_use_stall is 0 the cycle after.

Decomposition:
- rv32i_types package: rv32i_word, rv32i_reg, rv32i_control_word (with mem_read), rv32i_opcode enum (op_reg, op_imm, op_load, op_store, op_br, op_lui, op_auipc, op_jal, op_jalr).
- Also add uses_rs1/uses_rs2 as package functions so decode can share them.
- One sub-module: load_use_detect (combinational), producing load_use_stall from EX/ID fields.

Test Plan:
- Reset, then ID addi x1,x0,5 (ID_valid=1, pc=0x64, imm=5) -> next cycle EX_valid=1, EX_pc=0x64, EX_imm=5, EX_rd_num=1.
- EX holds lw x5 and ID holds add x6,x5,x7 -> load_use_stall=1 that cycle. Next cycle EX_valid=0 with ctrl 0; the add enters EX the cycle after.
- EX holds lw x5 and ID holds addi x6,x0,1 (rs2 field=5) -> load_use_stall=0 (op_imm does not use rs2).
- EX holds lw x0 and ID uses x0 -> load_use_stall=0.
- stall_in=1 for 3 cycles with EX rs1=x3, WB writes x3=0xDEADBEEF in cycle 2 -> EX_rs1_data=0xDEADBEEF after that edge, other fields unchanged. WB write to x0 -> no change.
- flush=1 together with stall_in=1 and load_use condition -> EX_valid=0, load_use_stall=0. rst=1 during stall -> all outputs at reset values, EX_pc=0x60.
